// File: rtl/frame_stream_source.sv
// Frame streamer: reads NUM_CH words from a one-cycle-latency frame buffer and
// emits them as a single Avalon-ST packet through a 2-entry output buffer.
module frame_stream_source #(
    parameter int unsigned NUM_CH = 320,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              busy,
    output logic              frame_done,
    output logic [15:0]       frame_drop_cnt,
    output logic [ADDR_W-1:0] buf_address,
    output logic              buf_rden,
    input  logic [15:0]       buf_q,
    output logic [15:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_startofpacket,
    output logic              out_endofpacket,
    output logic              out_empty
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(NUM_CH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StDrain
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [15:0]       drop_q, drop_d;
    logic              done_q, done_d;
    logic              inflight_q;

    logic [15:0]       mem_q [2];
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q, count_d;

    logic              pop;
    logic              push;
    logic              last_pop;
    logic [2:0]        committed;

    always_comb begin
        pop       = (count_q != 2'd0) && out_ready;
        push      = inflight_q;
        last_pop  = pop && (word_cnt_q == LastAddr);
        // Slots already spoken for once this cycle's pop frees its entry.
        committed = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        count_d   = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_comb begin
        state_d    = state_q;
        rd_addr_d  = rd_addr_q;
        word_cnt_d = word_cnt_q;
        drop_d     = drop_q;
        done_d     = 1'b0;
        buf_rden   = 1'b0;

        if (pop) begin
            word_cnt_d = word_cnt_q + ADDR_W'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (frame_start) begin
                    state_d    = StStream;
                    rd_addr_d  = '0;
                    word_cnt_d = '0;
                end
            end
            StStream: begin
                if (committed < 3'd2) begin
                    buf_rden  = 1'b1;
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                    if (rd_addr_q == LastAddr) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last_pop) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (frame_start && (state_q != StIdle) && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            rd_addr_q  <= '0;
            word_cnt_q <= '0;
            drop_q     <= '0;
            done_q     <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_addr_q  <= rd_addr_d;
            word_cnt_q <= word_cnt_d;
            drop_q     <= drop_d;
            done_q     <= done_d;
            inflight_q <= buf_rden;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= buf_q;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

    always_comb begin
        busy              = (state_q != StIdle);
        frame_done        = done_q;
        frame_drop_cnt    = drop_q;
        buf_address       = buf_rden ? rd_addr_q : '0;
        out_valid         = (count_q != 2'd0);
        out_data          = out_valid ? mem_q[rd_ptr_q] : 16'h0000;
        out_startofpacket = out_valid && (word_cnt_q == '0);
        out_endofpacket   = out_valid && (word_cnt_q == LastAddr);
        out_empty         = 1'b0;
    end

endmodule

// File: tb/tb_frame_stream_source.sv
// Randomized scoreboard bench for frame_stream_source (NUM_CH=320 and NUM_CH=4 instances).
module tb_frame_stream_source;

    localparam int NCH = 320;
    localparam int AW  = 9;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b1;
    logic          frame_start = 1'b0;
    logic          busy, frame_done;
    logic [15:0]   frame_drop_cnt;
    logic [AW-1:0] buf_address;
    logic          buf_rden;
    logic [15:0]   buf_q = '0;
    logic [15:0]   out_data;
    logic          out_valid, out_ready, sop, eop, out_empty;

    frame_stream_source #(.NUM_CH(NCH), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .busy(busy),
        .frame_done(frame_done), .frame_drop_cnt(frame_drop_cnt), .buf_address(buf_address),
        .buf_rden(buf_rden), .buf_q(buf_q), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_startofpacket(sop), .out_endofpacket(eop),
        .out_empty(out_empty)
    );

    // Small instance for the short-frame case.
    logic        fs4 = 1'b0;
    logic        busy4, done4;
    logic [15:0] drop4;
    logic [1:0]  addr4;
    logic        rden4;
    logic [15:0] q4 = '0;
    logic [15:0] d4;
    logic        v4, s4, e4, empty4;
    logic        rdy4 = 1'b1;

    frame_stream_source #(.NUM_CH(4), .ADDR_W(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .frame_start(fs4), .busy(busy4), .frame_done(done4),
        .frame_drop_cnt(drop4), .buf_address(addr4), .buf_rden(rden4), .buf_q(q4),
        .out_data(d4), .out_valid(v4), .out_ready(rdy4), .out_startofpacket(s4),
        .out_endofpacket(e4), .out_empty(empty4)
    );

    logic [15:0] mem [NCH];
    always @(posedge clk) if (buf_rden) buf_q <= mem[buf_address];
    always @(posedge clk) if (rden4) q4 <= 16'h2000 + 16'(addr4);

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard entries are {data, sop, eop}.
    logic [17:0] exp_q [$];
    logic [17:0] got4 [$];

    bit rand_ready = 1'b0;
    bit ready_lvl  = 1'b1;
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_lvl;
        end
    end

    int          cyc = 0;
    int          popped = 0;
    int          rd_total = 0;
    int          outstanding = 0;
    int          done_cnt = 0;
    int          done4_cnt = 0;
    int          sop_cyc = 0;
    int          eop_cyc = 0;
    bit          prev_stall = 1'b0;
    bit          prev_eop_hs = 1'b0;
    logic [17:0] prev_word = '0;

    always @(negedge clk) begin : monitor
        logic        hs;
        logic [17:0] w;
        cyc++;
        if (!rst_n) begin
            prev_stall  = 1'b0;
            prev_eop_hs = 1'b0;
            outstanding = 0;
        end else begin
            hs = out_valid && out_ready;
            check("frame_done_timing", frame_done, prev_eop_hs);
            check("out_empty", out_empty, 1'b0);
            if (!out_valid) check("idle_outputs_zero", {out_data, sop, eop}, 18'h0);
            if (prev_stall) check("stall_hold", {out_valid, out_data, sop, eop}, {1'b1, prev_word});
            if (!buf_rden) check("addr_zero_no_rden", buf_address, '0);
            else check("no_overflow", (outstanding - (hs ? 1 : 0) + 1) <= 2, 1'b1);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got %h expected none", out_data);
                end else begin
                    w = exp_q.pop_front();
                    check("word", {out_data, sop, eop}, w);
                end
                popped++;
                if (sop) sop_cyc = cyc;
                if (eop) eop_cyc = cyc;
            end
            if (buf_rden) rd_total++;
            outstanding += (buf_rden ? 1 : 0) - (hs ? 1 : 0);
            if (frame_done) done_cnt++;
            prev_stall  = out_valid && !out_ready;
            prev_word   = {out_data, sop, eop};
            prev_eop_hs = hs && eop;
            if (v4 && rdy4) got4.push_back({d4, s4, e4});
            if (done4) done4_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_frame();
        for (int i = 0; i < NCH; i++) exp_q.push_back({mem[i], i == 0, i == NCH - 1});
    endtask

    task automatic start_frame();
        push_frame();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (!frame_done) begin
            failures++;
            $display("FAIL %s: frame_done got 0 expected 1 within 5000 cycles", name);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {busy, frame_done, frame_drop_cnt, buf_rden, buf_address, out_valid,
                     out_data, sop, eop}, 64'h0);
    endtask

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        int base;
        for (int i = 0; i < NCH; i++) mem[i] = 16'h1000 + 16'(i);

        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset_outputs");
        tick();
        tick();
        rst_n = 1'b1;

        // Nominal frame with latency and throughput checks.
        ready_lvl = 1'b1;
        push_frame();
        tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("latency_e0", out_valid, 1'b0);
        tick();
        check("latency_e1", out_valid, 1'b0);
        tick();
        check("latency_e2", {out_valid, out_data, sop}, {1'b1, 16'h1000, 1'b1});
        wait_done("nominal_done");
        check("throughput", eop_cyc - sop_cyc, NCH - 1);
        check("nominal_drop", frame_drop_cnt, 16'd0);

        // Random backpressure.
        rand_ready = 1'b1;
        start_frame();
        wait_done("random_ready_done");
        rand_ready = 1'b0;
        check("random_ready_drained", exp_q.size(), 0);

        // Dropped starts, restart in the frame_done cycle, drop in the eop cycle.
        start_frame();
        repeat (20) tick();
        for (int k = 0; k < 3; k++) begin
            frame_start = 1'b1;
            tick();
            frame_start = 1'b0;
            repeat (1 + $urandom_range(0, 30)) tick();
        end
        wait_done("drop_frame_done");
        push_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("drop_count_3", frame_drop_cnt, 16'd3);
        check("restart_busy", busy, 1'b1);
        n = 0;
        while (!(out_valid && eop && out_ready) && n < 2000) begin
            tick();
            n++;
        end
        check("eop_seen", out_valid && eop, 1'b1);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        wait_done("restart_done");
        check("drop_count_eop", frame_drop_cnt, 16'd4);

        // Reset at word 100, then a clean full frame.
        start_frame();
        base = popped;
        n = 0;
        while ((popped - base) < 100 && n < 1000) begin
            tick();
            n++;
        end
        check("reached_word_100", popped - base, 100);
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("midframe_reset_outputs");
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        start_frame();
        wait_done("post_reset_done");
        check("post_reset_drained", exp_q.size(), 0);

        // Ready held low from the start.
        ready_lvl = 1'b0;
        tick();
        base = rd_total;
        start_frame();
        repeat (10) tick();
        check("stall_head", {out_valid, out_data, sop}, {1'b1, mem[0], 1'b1});
        check("stall_reads", rd_total - base, 2);
        ready_lvl = 1'b1;
        wait_done("stall_done");

        // Random buffer contents with random backpressure.
        for (int i = 0; i < NCH; i++) mem[i] = 16'($urandom);
        rand_ready = 1'b1;
        start_frame();
        wait_done("random_data_done");
        rand_ready = 1'b0;
        tick();
        check("frames_completed", done_cnt, 7);
        check("scoreboard_empty", exp_q.size(), 0);

        // Short frame.
        tick();
        fs4 = 1'b1;
        tick();
        fs4 = 1'b0;
        repeat (20) tick();
        check("short_count", got4.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got4.size())
                check("short_word", got4[i], {16'h2000 + 16'(i), i == 0, i == 3});
        end
        check("short_done_once", done4_cnt, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
